// File: rtl/riscv_pkg.sv
// Shared integer-core types; this slice carries the writeback arbiter's entry
// format and default sizing.
package riscv_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic        live;
        reg_idx_t    rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam int WB_DEPTH        = 4;
    localparam int WB_STARVE_LIMIT = 3;

endpackage

// File: rtl/wb_fifo.sv
// In-order load buffer for the writeback arbiter: circular queue of wb_entry_t
// with push, pop, kill-by-rd and an oldest-to-youngest read-out for queries.
// Optional macro WB_FWD_EN adds the per-entry data read-out.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  kill,
    input  reg_idx_t              kill_rd,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty,
    output logic     [DEPTH-1:0]  age_live,
    output reg_idx_t [DEPTH-1:0]  age_rd
`ifdef WB_FWD_EN
    ,
    output logic [DEPTH-1:0][31:0] age_data
`endif
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] count;

    // The extra pointer bit makes count reach DEPTH exactly when full.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = count[PW];
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].rd == kill_rd) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end
        if (push && !full) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_entry;
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    // Index 0 of the read-out is the head, so later indices are younger.
    always_comb begin
        age_live = '0;
        age_rd   = '0;
`ifdef WB_FWD_EN
        age_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            age_live[i] = mem_q[rd_ptr_q[PW-1:0] + PW'(i)].live && ((PW+1)'(i) < count);
            age_rd[i]   = mem_q[rd_ptr_q[PW-1:0] + PW'(i)].rd;
`ifdef WB_FWD_EN
            age_data[i] = mem_q[rd_ptr_q[PW-1:0] + PW'(i)].data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered loads onto the single
// register-file write port and answers pending-write queries. Optional macro WB_FWD_EN.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH        = WB_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  reg_idx_t    alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  reg_idx_t    ld_rd,
    input  logic [31:0] ld_data,
    output logic        RegWrite,
    output logic [4:0]  rd,
    output logic [31:0] Rd,
    input  reg_idx_t    q_rs1,
    input  reg_idx_t    q_rs2,
    output logic        q_hit1,
    output logic        q_hit2
`ifdef WB_FWD_EN
    ,
    output logic [31:0] q_data1,
    output logic [31:0] q_data2
`endif
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic          wr_en_q, wr_en_d;
    reg_idx_t      wr_idx_q, wr_idx_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    logic      starve, alu_fire, ld_fire, pop, bypass, push, kill;
    wb_entry_t head, push_entry;
    logic      full, empty;

    logic     [DEPTH-1:0] age_live;
    reg_idx_t [DEPTH-1:0] age_rd;
`ifdef WB_FWD_EN
    logic [DEPTH-1:0][31:0] age_data;
    logic [1:0][31:0]       q_val;
`endif
    reg_idx_t [1:0] q_idx;
    logic     [1:0] q_hit_v;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (kill),
        .kill_rd    (alu_rd),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .age_live   (age_live),
        .age_rd     (age_rd)
`ifdef WB_FWD_EN
        ,
        .age_data   (age_data)
`endif
    );

    always_comb begin
        starve     = !rst && !empty && (starve_cnt_q == LIMIT);
        alu_ready  = !rst && !starve;
        ld_ready   = !rst && !full;
        alu_fire   = alu_valid && alu_ready;
        ld_fire    = ld_valid && ld_ready;
        pop        = 1'b0;
        bypass     = 1'b0;
        wr_en_d    = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;

        if (starve || (!alu_fire && !rst && !empty)) begin
            pop       = 1'b1;
            wr_en_d   = head.live;
            wr_idx_d  = head.rd;
            wr_data_d = head.data;
        end else if (alu_fire) begin
            wr_en_d   = (alu_rd != '0);
            wr_idx_d  = alu_rd;
            wr_data_d = alu_data;
        end else if (ld_fire) begin
            bypass    = 1'b1;
            wr_en_d   = (ld_rd != '0);
            wr_idx_d  = ld_rd;
            wr_data_d = ld_data;
        end

        // A same-cycle ALU result to the same register is younger, so the load dies here.
        kill       = alu_fire && (alu_rd != '0);
        push       = ld_fire && !bypass && (ld_rd != '0) && !(kill && (alu_rd == ld_rd));
        push_entry = '{live: 1'b1, rd: ld_rd, data: ld_data};

        starve_cnt_d = starve_cnt_q;
        if (empty || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_idx_q     <= '0;
            wr_data_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_idx_q     <= wr_idx_d;
            wr_data_q    <= wr_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign RegWrite = wr_en_q;
    assign rd       = wr_idx_q;
    assign Rd       = wr_data_q;

    assign q_idx[0] = q_rs1;
    assign q_idx[1] = q_rs2;

    // Search oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        q_hit_v = '0;
`ifdef WB_FWD_EN
        q_val = '0;
`endif
        for (int p = 0; p < 2; p++) begin
            if (wr_en_q && (wr_idx_q == q_idx[p])) begin
                q_hit_v[p] = 1'b1;
`ifdef WB_FWD_EN
                q_val[p] = wr_data_q;
`endif
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (age_live[i] && (age_rd[i] == q_idx[p])) begin
                    q_hit_v[p] = 1'b1;
`ifdef WB_FWD_EN
                    q_val[p] = age_data[i];
`endif
                end
            end
            if (rst || (q_idx[p] == '0)) begin
                q_hit_v[p] = 1'b0;
`ifdef WB_FWD_EN
                q_val[p] = '0;
`endif
            end
        end
    end

    assign q_hit1 = q_hit_v[0];
    assign q_hit2 = q_hit_v[1];
`ifdef WB_FWD_EN
    assign q_data1 = q_val[0];
    assign q_data2 = q_val[1];
`endif

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter on the writer side of the integer register file. It merges single-cycle ALU results and variable-latency load results into the register file's single write port (`RegWrite`/`rd`/`Rd`), buffering loads in a small in-order queue. It also answers pending-write queries from the hazard unit for the two source indices being read.

## Interface
Parameters:
- `DEPTH`, 4: load buffer entries; power of 2, ≥2.
- `STARVE_LIMIT`, 3: consecutive cycles a buffered load may wait before the ALU is held off.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `alu_valid` in 1: ALU result present.
- `alu_ready` out 1: ALU result accepted this cycle. The producer holds its result while this is 0.
- `alu_rd` in 5 (`reg_idx_t`): ALU destination register.
- `alu_data` in 32: ALU result value.
- `ld_valid` in 1: load result present.
- `ld_ready` out 1: load result accepted this cycle.
- `ld_rd` in 5 (`reg_idx_t`): load destination register.
- `ld_data` in 32: load result value.
- `RegWrite` out 1: register file write enable.
- `rd` out 5: register file write index.
- `Rd` out 32: register file write value.
- `q_rs1`, `q_rs2` in 5 each: source indices being read this cycle.
- `q_hit1`, `q_hit2` out 1 each: a pending write targets `q_rs1`/`q_rs2`.
- `q_data1`, `q_data2` out 32 each: youngest pending value for `q_rs1`/`q_rs2`. Present only with `WB_FWD_EN`.

## Operation
Program-order contract:
- Every result presented is younger than all buffered entries.
- When ALU and load results are accepted in the same cycle, the load is the older of the two.

Handshakes and queue entry:
- A transfer occurs when valid and ready are both 1.
- `ld_ready` = buffer not full.
- `alu_ready` = 1, except in a starve cycle, where it is 0.
- Results with index 0 are accepted and discarded. They never enter the buffer and never write.
- Each buffer entry holds `{live, rd, data}`.

Priority, evaluated each cycle:
1. Starve: the buffer is non-empty and the starve counter equals `STARVE_LIMIT`. The head pops to the output register and the ALU is held off.
2. Otherwise, if `alu_valid`, the ALU result goes to the output register.
3. Otherwise, if the buffer is non-empty, the head pops.
4. Otherwise, if `ld_valid`, the load bypasses the buffer straight to the output register.
- Any accepted load that was not bypassed is enqueued at the tail. A push and a pop may happen in the same cycle.

Write-after-write kill:
- An accepted ALU result with destination r clears `live` on every buffered entry with `rd`==r.
- It also prevents a same-cycle accepted load to r from being enqueued or written.
- Popping a non-live entry frees its slot. The output register gets `RegWrite`=0 that cycle.

Starve counter:
- Increments on each cycle where the buffer is non-empty and no pop occurs.
- Clears on any pop and whenever the buffer is empty.
- Saturates at `STARVE_LIMIT`.

Queries:
- Sources searched: the output register (when `RegWrite`=1) and live buffer entries.
- Youngest match wins: tail-most buffer entry first, then the output register.
- A query index of 0 never hits.
- Current-cycle inputs are not searched.

## Timing
- Write outputs are registered.
  - ALU result accepted in cycle N gives `RegWrite`/`rd`/`Rd` valid in N+1.
  - A bypassed load has the same N+1 latency.
  - A buffered load writes in the cycle after it pops.
- `alu_ready`, `ld_ready`, `q_hit*` and `q_data*` are combinational from registered state plus current inputs.
- Reset values:
  - `RegWrite`=0, `rd`=0, `Rd`=0.
  - Buffer empty, all `live`=0, starve counter 0.
  - `alu_ready`, `ld_ready` and `q_hit*` forced 0 while `rst`=1; `q_data*`=0.
- Reset mid-operation: buffered and in-flight results are dropped with no write. Producers must re-present after reset.
- Full buffer: `ld_ready`=0 even if a pop occurs in the same cycle. There is no same-cycle full pass-through.
- Pointers wrap modulo `DEPTH`. Full vs empty is distinguished by an extra pointer bit.

## Configuration
- `WB_FWD_EN` defined: `q_data1`/`q_data2` are present and return the youngest pending value, so the hazard unit can forward instead of stalling.
- `WB_FWD_EN` undefined: those ports and their data muxes are absent. Only `q_hit*` exists and the hazard unit stalls on a hit.

## Structure
- Add to `riscv_pkg`:
  - `wb_entry_t` struct `{logic live; reg_idx_t rd; logic [31:0] data}`.
  - `WB_DEPTH` = 4.
  - `WB_STARVE_LIMIT` = 3.
- Sub-module `wb_fifo`: circular buffer of `wb_entry_t` with push, pop, kill-by-rd, and a per-entry read-out for the query search.
- Arbitration, starve counter, output register and query logic live in `wb_arbiter`.

## Test plan
- ALU valid with `alu_rd`=5, `alu_data`=0xA5, idle loads → next cycle `RegWrite`=1, `rd`=5, `Rd`=0xA5.
- Four loads to r1..r4 while the ALU is valid every cycle → after 3 waiting cycles `alu_ready`=0 for one cycle and r1 writes. The remaining loads drain at the same rate, and `ld_ready`=0 while the buffer holds 4.
- Load to r7=0x11 buffered, then ALU to r7=0x22 → the load's pop gives `RegWrite`=0, and r7 ends at 0x22.
- ALU to r0=0xFF and load to r0 → both accepted, no write occurs, `q_hit` for index 0 = 0.
- Two loads to r9 (0x1 then 0x2) buffered, `q_rs1`=9 → `q_hit1`=1, and `q_data1`=0x2 with `WB_FWD_EN`.
- Buffer holding 2 entries, `rst` asserted for one cycle → outputs 0, readies 0 during reset, no writes afterwards.
